control_multi: RTL and testbench

//  Multicycle RV32I control FSM: sequences the shared datapath (one ALU, unified memory, IR/MDR/ALUOut/PCback regs).

---
 rtl/control_multi.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_control_multi.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_multi.sv
// Multicycle RV32I control FSM: sequences the shared ALU / unified memory datapath.
// Define RV32M_EN to route funct7=0x01 R-type instructions through the MULDIV state.
module control_multi #(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInstr,
  input  logic        iMemReady,
  input  logic        iMulDivDone,
  output logic        oIorD,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oIRWrite,
  output logic        oPCWrite,
  output logic        oPCWriteCond,
  output logic        oRegWrite,
  output logic [1:0]  oOrigAULA,
  output logic [1:0]  oOrigBULA,
  output logic [1:0]  oMem2Reg,
  output logic [1:0]  oOrigPC,
  output logic [4:0]  oALUControl,
  output logic        oMulDivStart,
  output logic        oIllegal,
  output logic        oFault,
  output logic [3:0]  oState
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU operation codes shared with the datapath's Parametros definitions
  localparam logic [4:0] OPAND  = 5'd0;
  localparam logic [4:0] OPOR   = 5'd1;
  localparam logic [4:0] OPXOR  = 5'd2;
  localparam logic [4:0] OPADD  = 5'd3;
  localparam logic [4:0] OPSUB  = 5'd4;
  localparam logic [4:0] OPSLT  = 5'd5;
  localparam logic [4:0] OPSLTU = 5'd6;
  localparam logic [4:0] OPSLL  = 5'd7;
  localparam logic [4:0] OPSRL  = 5'd8;
  localparam logic [4:0] OPSRA  = 5'd9;
  localparam logic [4:0] OPLUI  = 5'd10;
  localparam logic [4:0] OPNULL = 5'd31;
`ifdef RV32M_EN
  localparam logic [4:0] OPMUL    = 5'd11;
  localparam logic [4:0] OPMULH   = 5'd12;
  localparam logic [4:0] OPMULHSU = 5'd13;
  localparam logic [4:0] OPMULHU  = 5'd14;
  localparam logic [4:0] OPDIV    = 5'd15;
  localparam logic [4:0] OPDIVU   = 5'd16;
  localparam logic [4:0] OPREM    = 5'd17;
  localparam logic [4:0] OPREMU   = 5'd18;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MULDIV   = 4'd4,
    S_MEMADDR  = 4'd5,
    S_MEMREAD  = 4'd6,
    S_MEMWB    = 4'd7,
    S_MEMWRITE = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_WB_ALU   = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout;
  logic       mem_wait;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_bits;

  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign funct7 = iInstr[31:25];

  // funct7[5] selects SUB only for register-register forms; shifts honour it for both
  function automatic logic [4:0] alu_base_op(input logic [2:0] f3, input logic alt,
                                             input logic is_rtype);
    case (f3)
      3'b000:  alu_base_op = (is_rtype && alt) ? OPSUB : OPADD;
      3'b001:  alu_base_op = OPSLL;
      3'b010:  alu_base_op = OPSLT;
      3'b011:  alu_base_op = OPSLTU;
      3'b100:  alu_base_op = OPXOR;
      3'b101:  alu_base_op = alt ? OPSRA : OPSRL;
      3'b110:  alu_base_op = OPOR;
      default: alu_base_op = OPAND;
    endcase
  endfunction

`ifdef RV32M_EN
  logic muldiv_first_q, muldiv_first_d;

  function automatic logic [4:0] muldiv_op(input logic [2:0] f3);
    case (f3)
      3'b000:  muldiv_op = OPMUL;
      3'b001:  muldiv_op = OPMULH;
      3'b010:  muldiv_op = OPMULHSU;
      3'b011:  muldiv_op = OPMULHU;
      3'b100:  muldiv_op = OPDIV;
      3'b101:  muldiv_op = OPDIVU;
      3'b110:  muldiv_op = OPREM;
      default: muldiv_op = OPREMU;
    endcase
  endfunction

  assign muldiv_first_d = (state_d == S_MULDIV) && (state_q != S_MULDIV);
  assign unused_bits    = ^{iInstr[24:15], iInstr[11:7]};
`else
  assign unused_bits    = ^{iMulDivDone, iInstr[24:15], iInstr[11:7]};
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 8'd0;
    timeout    = 1'b0;
    mem_wait   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    case (state_q)
      S_FETCH: if (iMemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADDR;
          OPC_OPIMM:           state_d = S_EXEC_I;
          OPC_RTYPE: begin
            if (funct7 == 7'h00 || funct7 == 7'h20) state_d = S_EXEC_R;
`ifdef RV32M_EN
            else if (funct7 == 7'h01)               state_d = S_MULDIV;
`endif
            else                                    state_d = S_ILLEGAL;
          end
          OPC_LUI:    state_d = S_LUI;
          OPC_AUIPC:  state_d = S_AUIPC;
          OPC_BRANCH: state_d = S_BRANCH;
          OPC_JAL:    state_d = S_JAL;
          OPC_JALR:   state_d = S_JALR;
          default:    state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_WB_ALU;
`ifdef RV32M_EN
      // Done is ignored in the start cycle; the unit cannot answer that fast
      S_MULDIV: if (!muldiv_first_q && iMulDivDone) state_d = S_WB_ALU;
`else
      S_MULDIV: state_d = S_FETCH;
`endif
      S_MEMADDR:  state_d = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (iMemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (iMemReady) state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
    // A ready response in the limit cycle still completes the access
    if (mem_wait && !iMemReady) begin
      if (wait_cnt_q == WAIT_MAX) begin
        timeout = 1'b1;
        state_d = S_FETCH;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef RV32M_EN
  always_ff @(posedge iCLK) begin
    if (iRST) muldiv_first_q <= 1'b0;
    else      muldiv_first_q <= muldiv_first_d;
  end
`endif

  always_comb begin
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oIRWrite     = 1'b0;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oRegWrite    = 1'b0;
    oOrigAULA    = 2'b00;
    oOrigBULA    = 2'b00;
    oMem2Reg     = 2'b00;
    oOrigPC      = 2'b00;
    oALUControl  = OPNULL;
    oMulDivStart = 1'b0;
    oIllegal     = 1'b0;
    oFault       = 1'b0;
    oState       = state_q;
    case (state_q)
      S_FETCH: begin
        oMemRead    = 1'b1;
        oOrigAULA   = 2'b01;
        oOrigBULA   = 2'b01;
        oALUControl = OPADD;
        oIRWrite    = iMemReady;
        oPCWrite    = iMemReady;
      end
      S_DECODE: begin
        oOrigAULA   = 2'b10;
        oOrigBULA   = 2'b10;
        oALUControl = OPADD;
      end
      S_EXEC_R: oALUControl = alu_base_op(funct3, funct7[5], 1'b1);
      S_EXEC_I: begin
        oOrigBULA   = 2'b10;
        oALUControl = alu_base_op(funct3, funct7[5], 1'b0);
      end
`ifdef RV32M_EN
      S_MULDIV: begin
        oALUControl  = muldiv_op(funct3);
        oMulDivStart = muldiv_first_q;
      end
`endif
      S_MEMADDR: begin
        oOrigBULA   = 2'b10;
        oALUControl = OPADD;
      end
      S_MEMREAD: begin
        oIorD    = 1'b1;
        oMemRead = 1'b1;
      end
      S_MEMWB: begin
        oRegWrite = 1'b1;
        oMem2Reg  = 2'b10;
      end
      S_MEMWRITE: begin
        oIorD     = 1'b1;
        oMemWrite = 1'b1;
      end
      S_BRANCH: begin
        oALUControl  = OPSUB;
        oPCWriteCond = 1'b1;
        oOrigPC      = 2'b01;
      end
      S_JAL: begin
        oRegWrite = 1'b1;
        oMem2Reg  = 2'b01;
        oPCWrite  = 1'b1;
        oOrigPC   = 2'b01;
      end
      S_JALR: begin
        oOrigBULA   = 2'b10;
        oALUControl = OPADD;
        oPCWrite    = 1'b1;
        oRegWrite   = 1'b1;
        oMem2Reg    = 2'b01;
      end
      S_LUI: begin
        oOrigBULA   = 2'b10;
        oALUControl = OPLUI;
      end
      S_AUIPC: begin
        oOrigAULA   = 2'b10;
        oOrigBULA   = 2'b10;
        oALUControl = OPADD;
      end
      S_WB_ALU:  oRegWrite = 1'b1;
      S_ILLEGAL: oIllegal  = 1'b1;
      default: ;
    endcase
    if (timeout) begin
      oFault       = 1'b1;
      oIRWrite     = 1'b0;
      oPCWrite     = 1'b0;
      oPCWriteCond = 1'b0;
      oRegWrite    = 1'b0;
      oMemWrite    = 1'b0;
    end
    // Outputs are forced quiet during reset so an aborted access never strobes
    if (iRST) begin
      oIorD        = 1'b0;
      oMemRead     = 1'b0;
      oMemWrite    = 1'b0;
      oIRWrite     = 1'b0;
      oPCWrite     = 1'b0;
      oPCWriteCond = 1'b0;
      oRegWrite    = 1'b0;
      oOrigAULA    = 2'b00;
      oOrigBULA    = 2'b00;
      oMem2Reg     = 2'b00;
      oOrigPC      = 2'b00;
      oALUControl  = 5'd0;
      oMulDivStart = 1'b0;
      oIllegal     = 1'b0;
      oFault       = 1'b0;
      oState       = 4'd0;
    end
  end

endmodule

// File: tb/tb_control_multi.sv
// Scoreboard bench for control_multi: per-cycle expected output vectors are queued with
// their stimulus and compared after the inputs settle, half a period away from the clock edge.
module tb_control_multi;

  localparam int WAIT_MAX = 4;

  localparam logic [4:0] OPAND  = 5'd0;
  localparam logic [4:0] OPADD  = 5'd3;
  localparam logic [4:0] OPSUB  = 5'd4;
  localparam logic [4:0] OPSRA  = 5'd9;
  localparam logic [4:0] OPLUI  = 5'd10;
  localparam logic [4:0] OPNULL = 5'd31;
`ifdef RV32M_EN
  localparam logic [4:0] OPMUL  = 5'd11;
`endif

  typedef logic [26:0] vec_t;
  typedef struct packed {
    logic        rst;
    logic [31:0] instr;
    logic        ready;
    logic        done;
  } stim_t;

  logic        clk;
  logic        iRST, iMemReady, iMulDivDone;
  logic [31:0] iInstr;
  logic        oIorD, oMemRead, oMemWrite, oIRWrite, oPCWrite, oPCWriteCond, oRegWrite;
  logic [1:0]  oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC;
  logic [4:0]  oALUControl;
  logic        oMulDivStart, oIllegal, oFault;
  logic [3:0]  oState;
  vec_t        obs;

  stim_t stim_q[$];
  vec_t  exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  control_multi #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .iCLK(clk), .iRST(iRST), .iInstr(iInstr), .iMemReady(iMemReady), .iMulDivDone(iMulDivDone),
    .oIorD(oIorD), .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oIRWrite(oIRWrite),
    .oPCWrite(oPCWrite), .oPCWriteCond(oPCWriteCond), .oRegWrite(oRegWrite),
    .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA), .oMem2Reg(oMem2Reg), .oOrigPC(oOrigPC),
    .oALUControl(oALUControl), .oMulDivStart(oMulDivStart), .oIllegal(oIllegal),
    .oFault(oFault), .oState(oState)
  );

  assign obs = {oState, oIorD, oMemRead, oMemWrite, oIRWrite, oPCWrite, oPCWriteCond, oRegWrite,
                oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oALUControl, oMulDivStart, oIllegal, oFault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en = {iord, memread, memwrite, irwrite, pcwrite, pcwritecond, regwrite}; pl = {start, illegal, fault}
  function automatic vec_t mk(input logic [3:0] st, input logic [6:0] en, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] m2r, input logic [1:0] opc,
                              input logic [4:0] alu, input logic [2:0] pl);
    return {st, en, a, b, m2r, opc, alu, pl};
  endfunction

  function automatic vec_t e_fetch(input logic r, input logic f);
    return mk(4'd0, {1'b0, 1'b1, 1'b0, r, r, 1'b0, 1'b0}, 2'b01, 2'b01, 2'b00, 2'b00, OPADD, {2'b00, f});
  endfunction
  function automatic vec_t e_decode();
    return mk(4'd1, 7'b0, 2'b10, 2'b10, 2'b00, 2'b00, OPADD, 3'b000);
  endfunction
  function automatic vec_t e_wb();
    return mk(4'd14, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, OPNULL, 3'b000);
  endfunction
  function automatic vec_t e_memaddr();
    return mk(4'd5, 7'b0, 2'b00, 2'b10, 2'b00, 2'b00, OPADD, 3'b000);
  endfunction
  function automatic vec_t e_memread(input logic f);
    return mk(4'd6, 7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, OPNULL, {2'b00, f});
  endfunction
  function automatic vec_t e_memwb();
    return mk(4'd7, 7'b0000001, 2'b00, 2'b00, 2'b10, 2'b00, OPNULL, 3'b000);
  endfunction
  function automatic vec_t e_memwrite();
    return mk(4'd8, 7'b1010000, 2'b00, 2'b00, 2'b00, 2'b00, OPNULL, 3'b000);
  endfunction
  function automatic vec_t e_illegal();
    return mk(4'd15, 7'b0, 2'b00, 2'b00, 2'b00, 2'b00, OPNULL, 3'b010);
  endfunction

  task automatic push(input logic rst, input logic [31:0] instr, input logic ready,
                      input logic done, input vec_t e);
    stim_t s;
    s.rst = rst; s.instr = instr; s.ready = ready; s.done = done;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    iRST = s.rst; iInstr = s.instr; iMemReady = s.ready; iMulDivDone = s.done;
    #2;
  endtask

  task automatic seq_alu(input logic [31:0] instr, input logic [3:0] st, input logic [1:0] b,
                         input logic [4:0] op);
    push(1'b0, instr, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, instr, 1'b1, 1'b0, e_decode());
    push(1'b0, instr, 1'b1, 1'b0, mk(st, 7'b0, 2'b00, b, 2'b00, 2'b00, op, 3'b000));
    push(1'b0, instr, 1'b1, 1'b0, e_wb());
  endtask

  task automatic test_reset();
    stim_t s; vec_t e; int k = 0;
    push(1'b1, 32'h00500093, 1'b1, 1'b1, '0);
    push(1'b1, 32'h00500093, 1'b1, 1'b1, '0);
    push(1'b0, 32'h00500093, 1'b0, 1'b0, e_fetch(1'b0, 1'b0));
    push(1'b1, 32'h00500093, 1'b0, 1'b0, '0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL reset step %0d: got %h want %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_alu();
    stim_t s; vec_t e; int k = 0;
    seq_alu(32'h00500093, 4'd3, 2'b10, OPADD);
    seq_alu(32'h0FF0F093, 4'd3, 2'b10, OPAND);
    seq_alu(32'h4030D093, 4'd3, 2'b10, OPSRA);
    seq_alu(32'h402081B3, 4'd2, 2'b00, OPSUB);
    seq_alu(32'h4020D1B3, 4'd2, 2'b00, OPSRA);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL alu step %0d: got %h want %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_load();
    stim_t s; vec_t e; int k = 0;
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_memaddr());
    for (int i = 0; i < 3; i++) push(1'b0, 32'h0000A103, 1'b0, 1'b0, e_memread(1'b0));
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_memread(1'b0));
    push(1'b0, 32'h0000A103, 1'b0, 1'b0, e_memwb());
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL load step %0d: got %h want %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_store_branch();
    stim_t s; vec_t e; int k = 0;
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, e_memaddr());
    push(1'b0, 32'h0020A023, 1'b0, 1'b0, e_memwrite());
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, e_memwrite());
    push(1'b0, 32'h00000463, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h00000463, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h00000463, 1'b1, 1'b0, mk(4'd9, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b01, OPSUB, 3'b000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL store_branch step %0d: got %h want %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_illegal();
    stim_t s; vec_t e; int k = 0;
    push(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, e_illegal());
    push(1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, e_fetch(1'b0, 1'b0));
    push(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL illegal step %0d: got %h want %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_timeout();
    stim_t s; vec_t e; int k = 0;
    for (int i = 0; i < WAIT_MAX; i++) push(1'b0, 32'h00500093, 1'b0, 1'b0, e_fetch(1'b0, 1'b0));
    push(1'b0, 32'h00500093, 1'b0, 1'b0, e_fetch(1'b0, 1'b1));
    for (int i = 0; i < WAIT_MAX; i++) push(1'b0, 32'h00500093, 1'b0, 1'b0, e_fetch(1'b0, 1'b0));
    push(1'b0, 32'h00500093, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h00500093, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h00500093, 1'b1, 1'b0, mk(4'd3, 7'b0, 2'b00, 2'b10, 2'b00, 2'b00, OPADD, 3'b000));
    push(1'b0, 32'h00500093, 1'b1, 1'b0, e_wb());
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_memaddr());
    for (int i = 0; i < WAIT_MAX; i++) push(1'b0, 32'h0000A103, 1'b0, 1'b0, e_memread(1'b0));
    push(1'b0, 32'h0000A103, 1'b0, 1'b0, e_memread(1'b1));
    push(1'b0, 32'h0000A103, 1'b0, 1'b0, e_fetch(1'b0, 1'b0));
    push(1'b1, 32'h0000A103, 1'b0, 1'b0, '0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL timeout step %0d: got %h want %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_muldiv();
    stim_t s; vec_t e; int k = 0;
    push(1'b0, 32'h022081B3, 1'b1, 1'b1, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h022081B3, 1'b1, 1'b1, e_decode());
`ifdef RV32M_EN
    push(1'b0, 32'h022081B3, 1'b1, 1'b1, mk(4'd4, 7'b0, 2'b00, 2'b00, 2'b00, 2'b00, OPMUL, 3'b100));
    for (int i = 1; i < 6; i++)
      push(1'b0, 32'h022081B3, 1'b1, 1'b0, mk(4'd4, 7'b0, 2'b00, 2'b00, 2'b00, 2'b00, OPMUL, 3'b000));
    push(1'b0, 32'h022081B3, 1'b1, 1'b1, mk(4'd4, 7'b0, 2'b00, 2'b00, 2'b00, 2'b00, OPMUL, 3'b000));
    push(1'b0, 32'h022081B3, 1'b1, 1'b0, e_wb());
`else
    push(1'b0, 32'h022081B3, 1'b1, 1'b1, e_illegal());
`endif
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL muldiv step %0d: got %h want %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s; vec_t e; int k = 0;
    push(1'b0, 32'h008000EF, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h008000EF, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h008000EF, 1'b1, 1'b0, mk(4'd10, 7'b0000101, 2'b00, 2'b00, 2'b01, 2'b01, OPNULL, 3'b000));
    push(1'b0, 32'h00008067, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h00008067, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h00008067, 1'b1, 1'b0, mk(4'd11, 7'b0000101, 2'b00, 2'b10, 2'b01, 2'b00, OPADD, 3'b000));
    seq_alu(32'h123452B7, 4'd12, 2'b10, OPLUI);
    push(1'b0, 32'h00001297, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h00001297, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h00001297, 1'b1, 1'b0, mk(4'd13, 7'b0, 2'b10, 2'b10, 2'b00, 2'b00, OPADD, 3'b000));
    push(1'b0, 32'h00001297, 1'b1, 1'b0, e_wb());
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL back_to_back step %0d: got %h want %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_reset_midop();
    stim_t s; vec_t e; int k = 0;
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_memaddr());
    push(1'b0, 32'h0000A103, 1'b0, 1'b0, e_memread(1'b0));
    push(1'b1, 32'h0000A103, 1'b0, 1'b0, '0);
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_memaddr());
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_memread(1'b0));
    push(1'b0, 32'h0000A103, 1'b1, 1'b0, e_memwb());
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, e_decode());
    push(1'b0, 32'h0020A023, 1'b1, 1'b0, e_memaddr());
    push(1'b1, 32'h0020A023, 1'b1, 1'b0, '0);
    push(1'b0, 32'h0020A023, 1'b0, 1'b0, e_fetch(1'b0, 1'b0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s); e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_midop step %0d: got %h want %h", k, obs, e); end
      k++;
    end
  endtask

  initial begin
    iRST = 1'b1; iInstr = 32'h0; iMemReady = 1'b0; iMulDivDone = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store_branch();
    test_illegal();
    test_timeout();
    test_muldiv();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
